// File: rtl/cdb_pkg.sv
// ============================================================================
// Module  : cdb_pkg
// Brief   : Shared widths, entry type and source indices for the CDB arbiter.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package cdb_pkg;

    localparam int CDB_DATA_W     = 32;
    localparam int CDB_ROB_W      = 4;
    localparam int CDB_FIFO_DEPTH = 2;

    // Queue count needs one extra bit so that a full queue is distinguishable.
    function automatic int cnt_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

    localparam int CNT_W = cnt_width(CDB_FIFO_DEPTH);

    typedef struct packed {
        logic [CDB_ROB_W-1:0]  robNum;
        logic [CDB_DATA_W-1:0] data;
    } cdb_entry_t;

    localparam int SRC_ADD  = 0;
    localparam int SRC_LOAD = 1;
    localparam int SRC_MUL  = 2;
    localparam int SRC_BNE  = 3;

endpackage

`default_nettype wire

// File: rtl/cdb_src_fifo.sv
// ============================================================================
// Module  : cdb_src_fifo
// Brief   : Per-source result queue with push/pop, head, count and flush.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module cdb_src_fifo
    import cdb_pkg::*;
#(
    parameter int DEPTH = CDB_FIFO_DEPTH,
    parameter int WIDTH = CDB_ROB_W + CDB_DATA_W,
    parameter int CNT_W = cnt_width(DEPTH)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             flush,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] push_data,
    output logic [WIDTH-1:0] head,
    output logic [CNT_W-1:0] count,
    output logic             ready
);

    localparam int               PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PTR_W-1:0] LAST  = PTR_W'(DEPTH - 1);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_rd_ptr;
    logic [PTR_W-1:0] r_wr_ptr;
    logic [CNT_W-1:0] r_count;
    logic             w_do_push;
    logic             w_do_pop;

    assign ready     = (r_count < CNT_W'(DEPTH));
    assign w_do_push = push & ready;
    assign w_do_pop  = pop & (r_count != '0);
    assign head      = r_mem[r_rd_ptr];
    assign count     = r_count;

    // Explicit wrap keeps a single-entry queue on index 0.
    always_ff @(posedge clock) begin
        if (reset || flush) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_mem[r_wr_ptr] <= push_data;
                r_wr_ptr        <= (r_wr_ptr == LAST) ? '0 : r_wr_ptr + 1'b1;
            end
            if (w_do_pop) begin
                r_rd_ptr <= (r_rd_ptr == LAST) ? '0 : r_rd_ptr + 1'b1;
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: rtl/cdb_arbiter.sv
// ============================================================================
// Module  : cdb_arbiter
// Brief   : Round-robin common-data-bus arbiter, NUM_SRC queues onto NUM_BUS lanes.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module cdb_arbiter
    import cdb_pkg::*;
#(
    parameter int NUM_SRC    = 4,
    parameter int NUM_BUS    = 2,
    parameter int DATA_W     = CDB_DATA_W,
    parameter int ROB_W      = CDB_ROB_W,
    parameter int FIFO_DEPTH = CDB_FIFO_DEPTH
) (
    input  logic                                        clock,
    input  logic                                        reset,
    input  logic                                        flush,
    input  logic [NUM_SRC-1:0]                          src_valid,
    output logic [NUM_SRC-1:0]                          src_ready,
    input  logic [NUM_SRC*ROB_W-1:0]                    src_robNum,
    input  logic [NUM_SRC*DATA_W-1:0]                   src_data,
    output logic [NUM_BUS-1:0]                          bus_iscast,
    output logic [NUM_BUS*ROB_W-1:0]                    bus_robNum,
    output logic [NUM_BUS*DATA_W-1:0]                   bus_data,
    output logic [NUM_SRC*($clog2(FIFO_DEPTH)+1)-1:0]   occupancy
);

    localparam int CNT_W = cnt_width(FIFO_DEPTH);
    localparam int SEL_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
    localparam int ENT_W = ROB_W + DATA_W;

    logic [ENT_W-1:0]    w_head [NUM_SRC];
    logic [CNT_W-1:0]    w_count [NUM_SRC];
    logic [NUM_SRC-1:0]  w_push;
    logic [NUM_SRC-1:0]  w_pop;
    logic [NUM_SRC-1:0]  w_nonempty;
    logic [NUM_BUS-1:0]  w_lane_valid;
    logic [SEL_W-1:0]    w_lane_src [NUM_BUS];
    logic [SEL_W-1:0]    w_rr_next;

    logic [SEL_W-1:0]          r_rr_ptr;
    logic [NUM_BUS-1:0]        r_bus_iscast;
    logic [NUM_BUS*ROB_W-1:0]  r_bus_robNum;
    logic [NUM_BUS*DATA_W-1:0] r_bus_data;

    generate
        for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
            cdb_src_fifo #(
                .DEPTH (FIFO_DEPTH),
                .WIDTH (ENT_W),
                .CNT_W (CNT_W)
            ) u_fifo (
                .clock     (clock),
                .reset     (reset),
                .flush     (flush),
                .push      (w_push[i]),
                .pop       (w_pop[i]),
                .push_data ({src_robNum[i*ROB_W +: ROB_W], src_data[i*DATA_W +: DATA_W]}),
                .head      (w_head[i]),
                .count     (w_count[i]),
                .ready     (src_ready[i])
            );
            assign w_push[i]                     = src_valid[i] & src_ready[i];
            assign w_nonempty[i]                 = (w_count[i] != '0);
            assign occupancy[i*CNT_W +: CNT_W]   = w_count[i];
        end
    endgenerate

    // Scan from rr_ptr; the j-th non-empty queue found takes lane j.
    always_comb begin
        int n;
        int idx;
        w_pop        = '0;
        w_lane_valid = '0;
        w_rr_next    = r_rr_ptr;
        n            = 0;
        idx          = 0;
        for (int j = 0; j < NUM_BUS; j++) begin
            w_lane_src[j] = '0;
        end
        for (int k = 0; k < NUM_SRC; k++) begin
            idx = int'(r_rr_ptr) + k;
            if (idx >= NUM_SRC) begin
                idx = idx - NUM_SRC;
            end
            if (w_nonempty[idx] && (n < NUM_BUS)) begin
                w_pop[idx]      = 1'b1;
                w_lane_valid[n] = 1'b1;
                w_lane_src[n]   = SEL_W'(idx);
                w_rr_next       = (idx == NUM_SRC - 1) ? '0 : SEL_W'(idx + 1);
                n               = n + 1;
            end
        end
    end

    // Flush discards this cycle's grants and leaves the round-robin pointer alone.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_rr_ptr     <= '0;
            r_bus_iscast <= '0;
            r_bus_robNum <= '0;
            r_bus_data   <= '0;
        end else if (flush) begin
            r_bus_iscast <= '0;
            r_bus_robNum <= '0;
            r_bus_data   <= '0;
        end else begin
            r_rr_ptr     <= w_rr_next;
            r_bus_iscast <= w_lane_valid;
            for (int j = 0; j < NUM_BUS; j++) begin
                if (w_lane_valid[j]) begin
                    {r_bus_robNum[j*ROB_W +: ROB_W], r_bus_data[j*DATA_W +: DATA_W]} <= w_head[w_lane_src[j]];
                end else begin
                    r_bus_robNum[j*ROB_W +: ROB_W]   <= '0;
                    r_bus_data[j*DATA_W +: DATA_W]   <= '0;
                end
            end
        end
    end

    assign bus_iscast = r_bus_iscast;
    assign bus_robNum = r_bus_robNum;
    assign bus_data   = r_bus_data;

endmodule

`default_nettype wire

// File: tb/tb_cdb_arbiter.sv
// ============================================================================
// Module  : tb_cdb_arbiter
// Brief   : Self-checking bench for cdb_arbiter against a queue-based model.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_cdb_arbiter;
    import cdb_pkg::*;

    localparam int NS = 4;
    localparam int NB = 2;
    localparam int DW = 32;
    localparam int RW = 4;
    localparam int FD = 2;
    localparam int CW = $clog2(FD) + 1;

    logic              clock = 1'b0;
    logic              reset = 1'b1;
    logic              flush = 1'b0;
    logic [NS-1:0]     src_valid = '0;
    logic [NS-1:0]     src_ready;
    logic [NS*RW-1:0]  src_robNum = '0;
    logic [NS*DW-1:0]  src_data = '0;
    logic [NB-1:0]     bus_iscast;
    logic [NB*RW-1:0]  bus_robNum;
    logic [NB*DW-1:0]  bus_data;
    logic [NS*CW-1:0]  occupancy;

    // Second instance with a single lane for the alternation check.
    logic              f_flush = 1'b0;
    logic [NS-1:0]     f_valid = '0;
    logic [NS-1:0]     f_ready;
    logic [NS*RW-1:0]  f_robNum = '0;
    logic [NS*DW-1:0]  f_data = '0;
    logic [0:0]        f_iscast;
    logic [RW-1:0]     f_bus_robNum;
    logic [DW-1:0]     f_bus_data;
    logic [NS*CW-1:0]  f_occupancy;

    int total = 0;
    int bad   = 0;

    cdb_entry_t mq [NS][$];
    int         rr = 0;

    always #5 clock = ~clock;

    cdb_arbiter #(.NUM_SRC(NS), .NUM_BUS(NB), .DATA_W(DW), .ROB_W(RW), .FIFO_DEPTH(FD)) u_dut (
        .clock      (clock),
        .reset      (reset),
        .flush      (flush),
        .src_valid  (src_valid),
        .src_ready  (src_ready),
        .src_robNum (src_robNum),
        .src_data   (src_data),
        .bus_iscast (bus_iscast),
        .bus_robNum (bus_robNum),
        .bus_data   (bus_data),
        .occupancy  (occupancy)
    );

    cdb_arbiter #(.NUM_SRC(NS), .NUM_BUS(1), .DATA_W(DW), .ROB_W(RW), .FIFO_DEPTH(FD)) u_dut1 (
        .clock      (clock),
        .reset      (reset),
        .flush      (f_flush),
        .src_valid  (f_valid),
        .src_ready  (f_ready),
        .src_robNum (f_robNum),
        .src_data   (f_data),
        .bus_iscast (f_iscast),
        .bus_robNum (f_bus_robNum),
        .bus_data   (f_bus_data),
        .occupancy  (f_occupancy)
    );

    task automatic set_src(input int i, input logic v, input logic [RW-1:0] rob, input logic [DW-1:0] d);
        src_valid[i]             = v;
        src_robNum[i*RW +: RW]   = rob;
        src_data[i*DW +: DW]     = d;
    endtask

    // One clock: check pre-edge state, advance the model, check the lanes after the edge.
    task automatic step();
        cdb_entry_t    exp_e [NB];
        logic [NB-1:0] exp_cast;
        logic [NS-1:0] rdy;
        int            gsrc [NB];
        int            n;
        int            idx;
        cdb_entry_t    e;
        for (int i = 0; i < NS; i++) begin
            rdy[i] = (mq[i].size() < FD);
            total++;
            if (src_ready[i] !== rdy[i]) begin
                bad++;
                $display("FAIL ready[%0d]: got %b expected %b", i, src_ready[i], rdy[i]);
            end
            total++;
            if (occupancy[i*CW +: CW] !== CW'(mq[i].size())) begin
                bad++;
                $display("FAIL occupancy[%0d]: got %0d expected %0d", i, occupancy[i*CW +: CW], mq[i].size());
            end
        end
        n = 0;
        for (int k = 0; k < NS; k++) begin
            idx = (rr + k) % NS;
            if (mq[idx].size() > 0 && n < NB) begin
                gsrc[n] = idx;
                n++;
            end
        end
        exp_cast = '0;
        for (int j = 0; j < NB; j++) exp_e[j] = '0;
        if (!reset && !flush) begin
            for (int j = 0; j < n; j++) begin
                exp_cast[j] = 1'b1;
                exp_e[j]    = mq[gsrc[j]][0];
            end
        end
        if (reset || flush) begin
            for (int i = 0; i < NS; i++) mq[i].delete();
            if (reset) rr = 0;
        end else begin
            for (int j = 0; j < n; j++) void'(mq[gsrc[j]].pop_front());
            for (int i = 0; i < NS; i++) begin
                if (src_valid[i] && rdy[i]) begin
                    e.robNum = src_robNum[i*RW +: RW];
                    e.data   = src_data[i*DW +: DW];
                    mq[i].push_back(e);
                end
            end
            if (n > 0) rr = (gsrc[n-1] + 1) % NS;
        end
        @(posedge clock);
        #1;
        for (int j = 0; j < NB; j++) begin
            total++;
            if (bus_iscast[j] !== exp_cast[j]) begin
                bad++;
                $display("FAIL iscast[%0d]: got %b expected %b", j, bus_iscast[j], exp_cast[j]);
            end
            total++;
            if (bus_robNum[j*RW +: RW] !== exp_e[j].robNum) begin
                bad++;
                $display("FAIL robNum[%0d]: got %h expected %h", j, bus_robNum[j*RW +: RW], exp_e[j].robNum);
            end
            total++;
            if (bus_data[j*DW +: DW] !== exp_e[j].data) begin
                bad++;
                $display("FAIL data[%0d]: got %h expected %h", j, bus_data[j*DW +: DW], exp_e[j].data);
            end
        end
    endtask

    task automatic idle_inputs();
        src_valid = '0;
        flush     = 1'b0;
        reset     = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset = 1'b1;
        step();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        step();
        total++;
        if ({bus_iscast, bus_robNum, bus_data, occupancy} !== '0 || src_ready !== '1) begin
            bad++;
            $display("FAIL reset_state: got cast=%b occ=%h ready=%b expected all-zero, ready=1111",
                     bus_iscast, occupancy, src_ready);
        end
    endtask

    task automatic test_single();
        do_reset();
        set_src(SRC_LOAD, 1'b1, 4'd5, 32'h0000_00AA);
        step();
        idle_inputs();
        total++;
        if (bus_iscast !== 2'b00) begin
            bad++;
            $display("FAIL single_early: got %b expected 00", bus_iscast);
        end
        step();
        total++;
        if (bus_iscast !== 2'b01 || bus_robNum[3:0] !== 4'd5 || bus_data[31:0] !== 32'hAA) begin
            bad++;
            $display("FAIL single_cast: got cast=%b rob=%h data=%h expected 01/5/aa",
                     bus_iscast, bus_robNum[3:0], bus_data[31:0]);
        end
        step();
        total++;
        if (bus_iscast !== 2'b00) begin
            bad++;
            $display("FAIL single_once: got %b expected 00", bus_iscast);
        end
    endtask

    task automatic test_contention();
        do_reset();
        for (int i = 0; i < NS; i++) set_src(i, 1'b1, RW'(i + 1), DW'(32'h100 + i));
        step();
        idle_inputs();
        step();
        total++;
        if (bus_iscast !== 2'b11 || bus_robNum !== 8'h21) begin
            bad++;
            $display("FAIL contention_1: got cast=%b rob=%h expected 11/21", bus_iscast, bus_robNum);
        end
        step();
        total++;
        if (bus_iscast !== 2'b11 || bus_robNum !== 8'h43) begin
            bad++;
            $display("FAIL contention_2: got cast=%b rob=%h expected 11/43", bus_iscast, bus_robNum);
        end
        step();
    endtask

    task automatic test_back_to_back();
        int seq [NS];
        do_reset();
        for (int i = 0; i < NS; i++) seq[i] = 0;
        for (int c = 0; c < 6; c++) begin
            for (int i = 0; i < NS; i++) set_src(i, 1'b1, RW'(i * 4 + (seq[i] % 4)), $urandom);
            for (int i = 0; i < NS; i++) if (mq[i].size() < FD) seq[i]++;
            step();
        end
        idle_inputs();
        repeat (6) step();
    endtask

    task automatic test_flush();
        do_reset();
        set_src(SRC_MUL, 1'b1, 4'hA, 32'h1111);
        step();
        set_src(SRC_MUL, 1'b1, 4'hB, 32'h2222);
        step();
        idle_inputs();
        flush = 1'b1;
        step();
        flush = 1'b0;
        total++;
        if (bus_iscast !== 2'b00 || occupancy !== '0) begin
            bad++;
            $display("FAIL flush: got cast=%b occ=%h expected 00/0", bus_iscast, occupancy);
        end
        set_src(SRC_MUL, 1'b1, 4'hC, 32'h3333);
        step();
        idle_inputs();
        step();
        total++;
        if (bus_iscast !== 2'b01 || bus_robNum[3:0] !== 4'hC) begin
            bad++;
            $display("FAIL flush_after: got cast=%b rob=%h expected 01/c", bus_iscast, bus_robNum[3:0]);
        end
        step();
    endtask

    task automatic test_reset_mid();
        do_reset();
        for (int c = 0; c < 5; c++) begin
            for (int i = 0; i < NS; i++) set_src(i, 1'b1, RW'($urandom), $urandom);
            step();
        end
        reset = 1'b1;
        step();
        total++;
        if ({bus_iscast, bus_robNum, bus_data, occupancy} !== '0) begin
            bad++;
            $display("FAIL reset_mid: got cast=%b rob=%h occ=%h expected zero", bus_iscast, bus_robNum, occupancy);
        end
        idle_inputs();
        total++;
        if (src_ready !== 4'hF) begin
            bad++;
            $display("FAIL reset_mid_ready: got %b expected 1111", src_ready);
        end
        step();
    endtask

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 600; c++) begin
            for (int i = 0; i < NS; i++) set_src(i, 1'($urandom_range(0, 2) != 0), RW'($urandom), $urandom);
            flush = ($urandom_range(0, 23) == 0);
            reset = ($urandom_range(0, 99) == 0);
            step();
        end
        idle_inputs();
        repeat (6) step();
    endtask

    task automatic test_fairness();
        int seq [2];
        int got;
        int cycles;
        logic [1:0] acc;
        logic [RW-1:0] exp_rob;
        do_reset();
        seq[0] = 0;
        seq[1] = 0;
        got    = 0;
        cycles = 0;
        while (got < 8 && cycles < 40) begin
            for (int i = 0; i < 2; i++) begin
                f_valid[i]              = 1'b1;
                f_robNum[i*RW +: RW]    = RW'(i * 4 + (seq[i] % 4));
                f_data[i*DW +: DW]      = DW'(100 + i * 4 + (seq[i] % 4));
            end
            acc = f_valid[1:0] & f_ready[1:0];
            @(posedge clock);
            #1;
            cycles++;
            for (int i = 0; i < 2; i++) if (acc[i]) seq[i]++;
            if (got > 0 || f_iscast[0]) begin
                exp_rob = RW'((got % 2) * 4 + (got / 2));
                total++;
                if (f_iscast[0] !== 1'b1 || f_bus_robNum !== exp_rob || f_bus_data !== DW'(100 + int'(exp_rob))) begin
                    bad++;
                    $display("FAIL fairness[%0d]: got cast=%b rob=%h data=%0d expected 1/%h/%0d",
                             got, f_iscast[0], f_bus_robNum, f_bus_data, exp_rob, 100 + int'(exp_rob));
                end
                got++;
            end
        end
        total++;
        if (got < 8) begin
            bad++;
            $display("FAIL fairness_timeout: got %0d broadcasts expected 8", got);
        end
        f_valid = '0;
    endtask

    initial begin
        test_reset();
        test_single();
        test_contention();
        test_back_to_back();
        test_flush();
        test_reset_mid();
        test_random();
        test_fairness();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
